// File: rtl/inst_fetch.sv
// Instruction fetch unit: one-request-at-a-time fetch FSM with redirect/discard handling.
// Optional one-entry skid buffer for bubble-free fetch when FETCH_SKID_EN is defined.
module inst_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] inst,
  output logic [7:0]  inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] inst_q, inst_d;
  logic [7:0]  inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        discard_q, discard_d;
  logic        transfer;
  logic        issue;

`ifdef FETCH_SKID_EN
  logic        side_q, side_d;
  logic        skid_full_q, skid_full_d;
  logic [15:0] skid_q, skid_d;
  logic [7:0]  skid_pc_q, skid_pc_d;
  logic        side_ack;
`endif

  assign transfer = valid_q & inst_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    discard_d = discard_q;
    issue     = 1'b0;
`ifdef FETCH_SKID_EN
    side_d      = side_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
    skid_pc_d   = skid_pc_q;
    side_ack    = side_q & mem_ack;
`endif

    unique case (state_q)
      StIdle: begin
        if (redirect) pc_d = redirect_pc;
        if (!halt) begin
          state_d = StReq;
          issue   = 1'b1;
        end
      end

      StReq: begin
        if (mem_ack) begin
          if (redirect) begin
            pc_d      = redirect_pc;
            discard_d = 1'b0;
            issue     = 1'b1;
          end else if (discard_q) begin
            // Stale response from a redirected request: drop it and refetch at the new PC.
            discard_d = 1'b0;
            issue     = 1'b1;
          end else begin
            inst_d    = mem_data;
            inst_pc_d = addr_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 8'd1;
            state_d   = StValid;
          end
        end else if (redirect) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end

      StValid: begin
`ifdef FETCH_SKID_EN
        if (redirect) begin
          valid_d     = 1'b0;
          skid_full_d = 1'b0;
          side_d      = 1'b0;
          pc_d        = redirect_pc;
          if (side_q && !mem_ack) begin
            // The in-flight request cannot be aborted; let it finish and drop its data.
            discard_d = 1'b1;
            state_d   = StReq;
          end else if (!halt) begin
            state_d = StReq;
            issue   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (side_ack) begin
            side_d = 1'b0;
            pc_d   = pc_q + 8'd1;
          end
          if (transfer) begin
            if (skid_full_q) begin
              inst_d      = skid_q;
              inst_pc_d   = skid_pc_q;
              skid_full_d = 1'b0;
            end else if (side_ack) begin
              inst_d    = mem_data;
              inst_pc_d = addr_q;
            end else begin
              valid_d = 1'b0;
              if (side_q) begin
                side_d  = 1'b0;
                state_d = StReq;
              end else if (!halt) begin
                state_d = StReq;
                issue   = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end
          end else if (side_ack) begin
            skid_d      = mem_data;
            skid_pc_d   = addr_q;
            skid_full_d = 1'b1;
          end
          if (state_d == StValid && !side_d && !skid_full_d && !halt) begin
            side_d = 1'b1;
            issue  = 1'b1;
          end
        end
`else
        if (redirect || transfer) begin
          valid_d = 1'b0;
          if (redirect) pc_d = redirect_pc;
          if (!halt) begin
            state_d = StReq;
            issue   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
`endif
      end

      default: state_d = StIdle;
    endcase

    // mem_addr only changes when a fresh request starts, so it stays put across redirects.
    if (issue) addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_q    <= 16'h0000;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
`ifdef FETCH_SKID_EN
      side_q      <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= 16'h0000;
      skid_pc_q   <= RESET_PC;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
`ifdef FETCH_SKID_EN
      side_q      <= side_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      skid_pc_q   <= skid_pc_d;
`endif
    end
  end

`ifdef FETCH_SKID_EN
  assign mem_req = (state_q == StReq) | side_q;
`else
  assign mem_req = (state_q == StReq);
`endif
  assign mem_addr   = addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: cycle table, scoreboard streaming, stall, PC wrap, reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, halt, redirect, mem_req, mem_ack, inst_valid, inst_ready;
  logic [7:0]  redirect_pc, mem_addr, inst_pc;
  logic [15:0] mem_data, inst;

  logic        b_mem_req, b_mem_ack, b_inst_valid;
  logic [7:0]  b_mem_addr, b_inst_pc;
  logic [15:0] b_mem_data, b_inst;

  inst_fetch #(.RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  inst_fetch #(.RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .halt(1'b0), .redirect(1'b0), .redirect_pc(8'h00),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_data(b_mem_data),
    .inst(b_inst), .inst_pc(b_inst_pc), .inst_valid(b_inst_valid), .inst_ready(1'b1)
  );

  typedef struct {
    logic        redirect;
    logic [7:0]  rpc;
    logic        halt;
    logic        ack;
    logic [15:0] data;
    logic        ready;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [15:0] exp_inst;
    logic [7:0]  exp_ipc;
  } vec_t;

  typedef struct {
    logic [15:0] inst;
    logic [7:0]  pc;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  bit   auto_ack = 1'b0;
  bit   sb_on = 1'b0;
  int   pops = 0;
  int   exp_seq = 0;
  int   n2 = 0;
  logic [7:0] b_exp [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic [7:0] rpc, input logic hlt,
                              input logic ack, input logic [15:0] data, input logic rdy,
                              input logic ereq, input logic [7:0] eaddr, input logic evld,
                              input logic [15:0] einst, input logic [7:0] eipc);
    vec_t v;
    v.redirect = rd;   v.rpc = rpc;       v.halt = hlt;       v.ack = ack;
    v.data = data;     v.ready = rdy;     v.exp_req = ereq;   v.exp_addr = eaddr;
    v.exp_valid = evld; v.exp_inst = einst; v.exp_ipc = eipc;
    return v;
  endfunction

  // Called 1 time unit after a rising edge: responds to requests, checks transfers, advances.
  task automatic step();
    exp_t e;
    if (auto_ack) begin
      mem_ack  = mem_req;
      mem_data = 16'hA000 + {8'h00, mem_addr};
      if (mem_req) begin
        e.inst = 16'hA000 + 16'(exp_seq);
        e.pc   = 8'(exp_seq);
        sb.push_back(e);
        exp_seq++;
      end
    end
    if (sb_on && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_transfer: got inst %0h, expected no transfer", inst);
      end else begin
        e = sb.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_inst_pc", inst_pc, e.pc);
        pops++;
      end
    end
    if (b_mem_req) begin
      if (n2 < 3) chk("wrap_mem_addr", b_mem_addr, b_exp[n2]);
      n2++;
    end
    b_mem_ack  = b_mem_req;
    b_mem_data = 16'hB000 + {8'h00, b_mem_addr};
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];
  int   reqs;
  int   w;

  initial begin
    b_exp[0] = 8'hFE; b_exp[1] = 8'hFF; b_exp[2] = 8'h00;
    vecs[0]  = mk(0, 8'h00, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 8'h00);
    vecs[1]  = mk(0, 8'h00, 0, 1, 16'hA000, 0, 1, 8'h00, 0, 16'h0000, 8'h00);
    vecs[2]  = mk(0, 8'h00, 0, 0, 16'h0000, 0, 0, 8'h00, 1, 16'hA000, 8'h00);
    vecs[3]  = mk(1, 8'h05, 0, 0, 16'h0000, 1, 0, 8'h00, 1, 16'hA000, 8'h00);
    vecs[4]  = mk(1, 8'h40, 0, 0, 16'h0000, 0, 1, 8'h05, 0, 16'h0000, 8'h00);
    vecs[5]  = mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h05, 0, 16'h0000, 8'h00);
    vecs[6]  = mk(0, 8'h00, 0, 1, 16'hA005, 0, 1, 8'h05, 0, 16'h0000, 8'h00);
    vecs[7]  = mk(1, 8'h80, 0, 1, 16'hA040, 0, 1, 8'h40, 0, 16'h0000, 8'h00);
    vecs[8]  = mk(1, 8'h90, 0, 0, 16'h0000, 0, 1, 8'h80, 0, 16'h0000, 8'h00);
    vecs[9]  = mk(1, 8'hA0, 0, 0, 16'h0000, 0, 1, 8'h80, 0, 16'h0000, 8'h00);
    vecs[10] = mk(0, 8'h00, 0, 1, 16'hA080, 0, 1, 8'h80, 0, 16'h0000, 8'h00);
    vecs[11] = mk(0, 8'h00, 1, 1, 16'hA0A0, 0, 1, 8'hA0, 0, 16'h0000, 8'h00);
    vecs[12] = mk(0, 8'h00, 1, 0, 16'h0000, 0, 0, 8'h00, 1, 16'hA0A0, 8'hA0);
    vecs[13] = mk(0, 8'h00, 1, 0, 16'h0000, 1, 0, 8'h00, 1, 16'hA0A0, 8'hA0);
    vecs[14] = mk(0, 8'h00, 1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 8'h00);
    vecs[15] = mk(1, 8'hFF, 1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 8'h00);
    vecs[16] = mk(0, 8'h00, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 8'h00);
    vecs[17] = mk(0, 8'h00, 0, 1, 16'hA0FF, 0, 1, 8'hFF, 0, 16'h0000, 8'h00);
    vecs[18] = mk(0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h00, 1, 16'hA0FF, 8'hFF);
    vecs[19] = mk(0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h00, 0, 16'h0000, 8'h00);

    rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    mem_ack = 1'b0; mem_data = 16'h0000; inst_ready = 1'b0;
    b_mem_ack = 1'b0; b_mem_data = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 8'h00);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_wrap_mem_addr", b_mem_addr, 8'hFE);
    chk("rst_wrap_inst_pc", b_inst_pc, 8'hFE);
    rst_n = 1'b1;

`ifndef FETCH_SKID_EN
    // Cycle-exact: redirects in VALID/REQ, redirect+ack, repeated redirects, halt, PC wrap.
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_ipc);
      end
      redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc; halt = vecs[i].halt;
      mem_ack = vecs[i].ack; mem_data = vecs[i].data; inst_ready = vecs[i].ready;
      step();
    end
`endif
    redirect = 1'b0; halt = 1'b0; mem_ack = 1'b0;

    // Streaming from PC 0 with same-cycle acks and an always-ready decoder.
    auto_ack = 1'b1; sb_on = 1'b1; inst_ready = 1'b1; exp_seq = 0; pops = 0;
    for (int i = 0; i < 20; i++) step();
    chk("stream_enough_transfers", pops >= 8, 1);

    // Decoder stalls for 5 cycles while an instruction is held.
    inst_ready = 1'b0;
    w = 0;
    while (!inst_valid && w < 10) begin
      step();
      w++;
    end
    chk("stall_valid_seen", inst_valid, 1);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst_valid", inst_valid, 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stall_sb_empty: got no pending entry, expected one");
      end else begin
        chk("stall_inst", inst, sb[0].inst);
        chk("stall_inst_pc", inst_pc, sb[0].pc);
      end
      if (mem_req) reqs++;
      step();
    end
`ifdef FETCH_SKID_EN
    chk("stall_extra_reqs", reqs, 1);
`else
    chk("stall_extra_reqs", reqs, 0);
`endif

    // Drain, then leave a request outstanding and reset in the middle of it.
    auto_ack = 1'b0; mem_ack = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_reset_mem_req", mem_req, 1);
    chk("pre_reset_addr_nonzero", mem_addr != 8'h00, 1);
    sb_on = 1'b0; sb.delete(); inst_ready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midreq_rst_mem_req", mem_req, 0);
    chk("midreq_rst_inst_valid", inst_valid, 0);
    chk("midreq_rst_mem_addr", mem_addr, 8'h00);
    chk("midreq_rst_inst", inst, 16'h0000);
    chk("midreq_rst_inst_pc", inst_pc, 8'h00);
    rst_n = 1'b1; mem_ack = 1'b1; mem_data = 16'hBEEF;
    step();
    chk("late_ack_inst_valid", inst_valid, 0);
    chk("late_ack_mem_req", mem_req, 1);
    chk("late_ack_mem_addr", mem_addr, 8'h00);
    mem_data = 16'h1234;
    step();
    mem_ack = 1'b0;
    chk("post_reset_inst_valid", inst_valid, 1);
    chk("post_reset_inst", inst, 16'h1234);
    chk("post_reset_inst_pc", inst_pc, 8'h00);
    chk("wrap_fetch_count", n2 >= 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port halt, input, 1, which blocks issue of new memory requests.
REQ-005 SHALL have port redirect, input, 1, a branch/jump request.
REQ-006 SHALL have port redirect_pc, input, 8, the branch target address.
REQ-007 SHALL have port mem_req, output, 1, the instruction memory read request.
REQ-008 SHALL have port mem_addr, output, 8, the read address.
REQ-009 SHALL have port mem_ack, input, 1, the read-complete strobe.
REQ-010 SHALL have port mem_data, input, 16, the read data, valid when mem_ack=1.
REQ-011 SHALL have port inst, output, 16, the instruction word sent to the decoder.
REQ-012 SHALL have port inst_pc, output, 8, the address of inst.
REQ-013 SHALL have port inst_valid, output, 1, which marks inst as valid.
REQ-014 SHALL have port inst_ready, input, 1, the decoder accept signal.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ and VALID.
REQ-016 IDLE SHALL go to REQ on the next cycle when halt=0.
REQ-017 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal the PC, both held stable until mem_ack; no request is ever aborted.
REQ-018 On mem_ack in REQ with no pending discard, the block SHALL register inst<=mem_data, inst_pc<=PC, inst_valid<=1 and PC<=PC+1, then go to VALID.
REQ-019 PC increment SHALL wrap modulo 256 (8'hFF -> 8'h00).
REQ-020 A transfer SHALL occur on any cycle with inst_valid=1 and inst_ready=1.
REQ-021 In VALID, inst, inst_pc and inst_valid SHALL hold until transfer.
REQ-022 On transfer, the block SHALL go to REQ, or to IDLE if halt=1, with inst_valid=0 the next cycle.
REQ-023 mem_req SHALL be 0 in IDLE and VALID.
REQ-024 Latency SHALL be: ack in cycle N gives inst_valid in cycle N+1; transfer in cycle M gives mem_req in cycle M+1.
REQ-025 Redirect in IDLE or VALID SHALL set PC<=redirect_pc and inst_valid<=0, then go to REQ, or to IDLE if halt=1; a transfer in the same cycle still counts as consumed.
REQ-026 Redirect in REQ without mem_ack SHALL set PC<=redirect_pc and a discard flag, and mem_addr SHALL keep its original value until ack.
REQ-027 An ack with the discard flag set SHALL drop its data, clear the flag, leave inst_valid at 0 and stay in REQ with mem_addr=redirect_pc.
REQ-028 Redirect in the same cycle as mem_ack in REQ SHALL drop the data, set PC<=redirect_pc and stay in REQ.
REQ-029 Multiple redirects before an ack SHALL use the last target.
REQ-030 halt SHALL never cancel an outstanding request or a valid instruction.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL enter IDLE with PC=RESET_PC, mem_req=0, mem_addr=RESET_PC, inst=16'h0000, inst_pc=RESET_PC, inst_valid=0 and the discard flag clear, even in the middle of a request.
REQ-032 An ack arriving after reset for a request made before reset SHALL be ignored, because mem_req=0 at that point.

Configuration
REQ-033 When FETCH_SKID_EN is defined, the block SHALL add a one-entry skid register.
REQ-034 With FETCH_SKID_EN, while VALID is not yet transferred, the block SHALL issue the next request.
REQ-035 With FETCH_SKID_EN, that request's data SHALL go into the skid register and load into inst on transfer, giving back-to-back inst_valid with no bubble.
REQ-036 With FETCH_SKID_EN, a redirect SHALL flush the skid register.
REQ-037 With FETCH_SKID_EN, no request SHALL be issued while the skid register is full.
REQ-038 Without FETCH_SKID_EN, the block SHALL behave exactly as REQ-015 to REQ-030: at most one instruction is in flight or held.

Verification
REQ-039 Scenario: reset, then mem_ack in the same cycle as every mem_req with data=16'hA000+addr, inst_ready=1 -> inst sequence 16'hA000, 16'hA001, ... with inst_pc 0, 1, ...
REQ-040 Scenario: RESET_PC=8'hFE, 3 fetches -> mem_addr sequence FE, FF, 00.
REQ-041 Scenario: inst_ready=0 for 5 cycles in VALID -> inst and inst_pc stable, mem_req=0 (no skid) or exactly one extra request (skid).
REQ-042 Scenario: redirect to 8'h40 while a request to 8'h05 awaits ack -> data from 05 never appears, next mem_addr=8'h40, next inst_pc=8'h40.
REQ-043 Scenario: redirect and mem_ack in the same cycle -> no inst_valid pulse, next request to redirect_pc.
REQ-044 Scenario: rst_n=0 during REQ -> next cycle mem_req=0, inst_valid=0, PC=RESET_PC; a late mem_ack is ignored.
